multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/ctrl_outdec.sv | 58 +++++
 rtl/multicycle_ctrl.sv | 83 ++++++++
 tb/tb_multicycle_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// datapath mux selects and the control word produced by the output decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       alusrca;
    logic       memtoreg;
    logic       regdst;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_word_t;

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational state -> control word decode. FETCH write enables follow
// mem_ready so the IR and PC load only on the cycle memory returns the word.
module ctrl_outdec
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      FETCH: begin
        cw.alusrcb = SRCB_FOUR;
        cw.irwrite = mem_ready;
        cw.pcwrite = mem_ready;
      end
      DECODE:  cw.alusrcb = SRCB_IMMSH;
      MEMADR, ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      MEMRD:   cw.iord = 1'b1;
      MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      RTYPEEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RD2;
        cw.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      BEQEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_RD2;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      ADDIWB:  cw.regwrite = 1'b1;
      JEX: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute,
// with all write enables held low while reset is asserted.
module multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     st_q, st_d;
  ctrl_word_t cw;
  logic       illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= FETCH;
    else          st_q <= st_d;
  end

  always_comb begin
    st_d    = FETCH;
    illegal = 1'b0;
    case (st_q)
      FETCH:   st_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: st_d = MEMADR;
          OP_RTYPE:     st_d = RTYPEEX;
          OP_BEQ:       st_d = BEQEX;
          OP_ADDI:      st_d = ADDIEX;
          OP_J:         st_d = JEX;
          default: begin
            st_d    = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEMADR:  st_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   st_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   st_d = mem_ready ? FETCH : MEMWR;
      RTYPEEX: st_d = RTYPEWB;
      ADDIEX:  st_d = ADDIWB;
      default: st_d = FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .state     (st_q),
    .mem_ready (mem_ready),
    .cw        (cw)
  );

  // Enables are gated by reset_n so an access in flight cannot complete once reset asserts.
  assign pcen       = reset_n & (cw.pcwrite | (cw.branch & zero));
  assign memwrite   = reset_n & cw.memwrite;
  assign irwrite    = reset_n & cw.irwrite;
  assign regwrite   = reset_n & cw.regwrite;
  assign illegal_op = reset_n & illegal;
  assign iord       = cw.iord;
  assign alusrca    = cw.alusrca;
  assign memtoreg   = cw.memtoreg;
  assign regdst     = cw.regdst;
  assign alusrcb    = cw.alusrcb;
  assign pcsrc      = cw.pcsrc;
  assign aluop      = cw.aluop;
  assign state      = st_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: instruction-level model predicts each cycle's state and
// controls; a negedge monitor compares the DUT against the queued predictions.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, memwrite, irwrite, regwrite, iord, alusrca, memtoreg, regdst;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal;
  } obs_t;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
    S_MEMWB = 4, S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7, S_BEQEX = 8,
    S_ADDIEX = 9, S_ADDIWB = 10, S_JEX = 11;
  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
    BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] op = 6'd0;
  logic       zero = 1'b0, mem_ready = 1'b0;
  logic       pcen, memwrite, irwrite, regwrite, iord, alusrca, memtoreg, regdst, illegal_op;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;

  obs_t sb[$];
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .alusrca(alusrca), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op),
    .state(state)
  );

  function automatic logic legal(input logic [5:0] o);
    return (o == RT) || (o == LW) || (o == SW) || (o == BEQ) || (o == ADDI) || (o == JMP);
  endfunction

  // Per-state control table as listed in the requirements; unlisted fields are 0.
  function automatic obs_t model(input logic [3:0] st, input logic mr, input logic z,
                                 input logic [5:0] o, input logic rst);
    obs_t e;
    e = '0;
    e.st = rst ? st : S_FETCH;
    case (e.st)
      S_FETCH:   begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      S_DECODE:  begin e.alusrcb = 2'b11; e.illegal = !legal(o); end
      S_MEMADR, S_ADDIEX: begin e.alusrca = 1; e.alusrcb = 2'b10; end
      S_MEMRD:   e.iord = 1;
      S_MEMWB:   begin e.memtoreg = 1; e.regwrite = 1; end
      S_MEMWR:   begin e.iord = 1; e.memwrite = 1; end
      S_RTYPEEX: begin e.alusrca = 1; e.aluop = 2'b10; end
      S_RTYPEWB: begin e.regdst = 1; e.regwrite = 1; end
      S_BEQEX:   begin e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01; e.pcen = z; end
      S_ADDIWB:  e.regwrite = 1;
      S_JEX:     begin e.pcsrc = 2'b10; e.pcen = 1; end
      default:   e = '0;
    endcase
    if (!rst) begin
      e.pcen = 0; e.irwrite = 0; e.memwrite = 0; e.regwrite = 0; e.illegal = 0;
    end
    return e;
  endfunction

  // One clock of stimulus: drive inputs just after the edge, predict this cycle.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic [5:0] o, input logic rst);
    @(posedge clk); #1;
    reset_n   = rst;
    mem_ready = mr;
    op        = o;
    zero      = 1'($urandom_range(0, 1));
    sb.push_back(model(st, mr, zero, o, rst));
  endtask

  // A memory-waiting state repeats until mem_ready; stalls capped to keep runs short.
  task automatic wait_st(input logic [3:0] st, input logic [5:0] o);
    logic mr;
    int n;
    n = 0;
    do begin
      mr = (n >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      cyc(st, mr, o, 1'b1);
      n++;
    end while (!mr);
  endtask

  task automatic issue(input logic [5:0] o);
    wait_st(S_FETCH, o);
    cyc(S_DECODE, 1'($urandom_range(0, 1)), o, 1'b1);
    case (o)
      LW:   begin cyc(S_MEMADR, 1'($urandom_range(0,1)), o, 1); wait_st(S_MEMRD, o);
                  cyc(S_MEMWB, 1'($urandom_range(0,1)), o, 1); end
      SW:   begin cyc(S_MEMADR, 1'($urandom_range(0,1)), o, 1); wait_st(S_MEMWR, o); end
      RT:   begin cyc(S_RTYPEEX, 1'($urandom_range(0,1)), o, 1);
                  cyc(S_RTYPEWB, 1'($urandom_range(0,1)), o, 1); end
      ADDI: begin cyc(S_ADDIEX, 1'($urandom_range(0,1)), o, 1);
                  cyc(S_ADDIWB, 1'($urandom_range(0,1)), o, 1); end
      BEQ:  cyc(S_BEQEX, 1'($urandom_range(0,1)), o, 1);
      JMP:  cyc(S_JEX, 1'($urandom_range(0,1)), o, 1);
      default: ;
    endcase
  endtask

  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{state, pcen, memwrite, irwrite, regwrite, iord, alusrca, memtoreg, regdst,
              alusrcb, pcsrc, aluop, illegal_op};
        vectors++;
        if (a !== e || (32'(memwrite) + 32'(regwrite) + 32'(irwrite)) > 1) begin
          miscompares++;
          $display("FAIL ctrl vec %0d t=%0t: dut st=%0d pcen=%b mw=%b ir=%b rw=%b iord=%b sa=%b m2r=%b rd=%b sb=%b pcs=%b aop=%b ill=%b | expected st=%0d pcen=%b mw=%b ir=%b rw=%b iord=%b sa=%b m2r=%b rd=%b sb=%b pcs=%b aop=%b ill=%b",
            vectors, $time, a.st, a.pcen, a.memwrite, a.irwrite, a.regwrite, a.iord, a.alusrca,
            a.memtoreg, a.regdst, a.alusrcb, a.pcsrc, a.aluop, a.illegal,
            e.st, e.pcen, e.memwrite, e.irwrite, e.regwrite, e.iord, e.alusrca,
            e.memtoreg, e.regdst, e.alusrcb, e.pcsrc, e.aluop, e.illegal);
        end
      end
    end
  end

  initial begin
    logic [5:0] ops [6];
    logic [5:0] o;
    int r, guard;
    ops = '{RT, LW, SW, BEQ, ADDI, JMP};

    // Held in reset with mem_ready toggling: FETCH, no enables.
    cyc(S_FETCH, 1'b1, RT, 1'b0);
    cyc(S_FETCH, 1'b0, RT, 1'b0);
    cyc(S_FETCH, 1'b1, RT, 1'b0);

    // Directed sequences, then a randomized instruction mix.
    issue(LW); issue(SW); issue(BEQ); issue(BEQ); issue(6'b111111);
    issue(RT); issue(ADDI); issue(JMP);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 7);
      if (r < 6)       o = ops[r];
      else if (r == 6) o = 6'b111111;
      else             o = 6'($urandom_range(0, 63));
      issue(o);
    end

    // Reset while a store waits on memory: write must drop at once, restart at FETCH.
    wait_st(S_FETCH, SW);
    cyc(S_DECODE, 1'b1, SW, 1'b1);
    cyc(S_MEMADR, 1'b0, SW, 1'b1);
    cyc(S_MEMWR, 1'b0, SW, 1'b1);
    cyc(S_MEMWR, 1'b0, SW, 1'b0);
    cyc(S_FETCH, 1'b1, SW, 1'b0);
    issue(LW);
    issue(JMP);

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
